// File: rtl/lsu_memex.sv
// MEMEX-stage load/store unit: single-cycle ITCM stores, req/ack data-bus
// accesses with timeout, and aligned/extended load data back to writeback.
module lsu_memex #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        invalid_MEMEX,
  input  logic        mem_re_MEMEX,
  input  logic        mem_we_MEMEX,
  input  logic        itcm_we_MEMEX,
  input  logic [31:0] alu_result_MEMEX,
  input  logic [1:0]  data_width_MEMEX,
  input  logic        lsu_sign_extend_MEMEX,
  input  logic [31:0] rs2_data_MEMEX,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        itcm_we,
  output logic [31:0] itcm_addr,
  output logic [31:0] itcm_wdata,
  output logic [3:0]  itcm_be,
  output logic [31:0] load_data_MEMEX,
  output logic        lsu_stall,
  output logic        lsu_misaligned,
  output logic        lsu_fault
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  state_t      state, state_nx;
  logic        access_valid;
  logic        misaligned_c;
  logic        issue_itcm;
  logic        issue_bus;
  logic        timeout_hit;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] word_addr_c;
  logic [1:0]  lat_addr_lo;
  logic [1:0]  lat_width;
  logic        lat_sign;
  logic [7:0]  cnt;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign access_valid = !invalid_MEMEX & (mem_re_MEMEX | mem_we_MEMEX | itcm_we_MEMEX);
  assign word_addr_c  = {alu_result_MEMEX[31:2], 2'b00};

  always_comb begin
    misaligned_c = 1'b0;
    be_c         = 4'b1111;
    wdata_c      = rs2_data_MEMEX;
    case (data_width_MEMEX)
      2'b00: begin
        be_c    = 4'b0001 << alu_result_MEMEX[1:0];
        wdata_c = {4{rs2_data_MEMEX[7:0]}};
      end
      2'b01: begin
        misaligned_c = alu_result_MEMEX[0];
        be_c         = 4'b0011 << {alu_result_MEMEX[1], 1'b0};
        wdata_c      = {2{rs2_data_MEMEX[15:0]}};
      end
      2'b10:   misaligned_c = (alu_result_MEMEX[1:0] != 2'b00);
      default: misaligned_c = 1'b1;
    endcase
  end

  // ITCM outranks the data bus; among bus requests the store outranks the load.
  assign issue_itcm  = access_valid & !misaligned_c & itcm_we_MEMEX;
  assign issue_bus   = access_valid & !misaligned_c & !itcm_we_MEMEX &
                       (mem_we_MEMEX | mem_re_MEMEX);
  assign timeout_hit = (cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    lsu_stall      = 1'b0;
    lsu_misaligned = 1'b0;
    itcm_we        = 1'b0;
    itcm_addr      = '0;
    itcm_wdata     = '0;
    itcm_be        = '0;
    case (state)
      IDLE: begin
        if (access_valid && misaligned_c) begin
          lsu_misaligned = 1'b1;
        end else if (issue_itcm) begin
          itcm_we    = 1'b1;
          itcm_addr  = word_addr_c;
          itcm_wdata = wdata_c;
          itcm_be    = be_c;
        end else if (issue_bus) begin
          lsu_stall = 1'b1;
          state_nx  = BUSY;
        end
      end
      BUSY: begin
        lsu_stall = 1'b1;
        if (dbus_ack || timeout_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane select: lat_addr_lo is 0/2 for halves, so one shift serves all widths.
  always_comb begin
    shifted  = dbus_rdata >> {lat_addr_lo, 3'b000};
    load_ext = dbus_rdata;
    case (lat_width)
      2'b00:   load_ext = {{24{lat_sign & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{lat_sign & shifted[15]}}, shifted[15:0]};
      default: load_ext = dbus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbus_req        <= 1'b0;
      dbus_we         <= 1'b0;
      dbus_addr       <= '0;
      dbus_wdata      <= '0;
      dbus_be         <= '0;
      load_data_MEMEX <= '0;
      lsu_fault       <= 1'b0;
      lat_addr_lo     <= '0;
      lat_width       <= '0;
      lat_sign        <= 1'b0;
      cnt             <= '0;
    end else begin
      lsu_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (issue_bus) begin
            dbus_req    <= 1'b1;
            dbus_we     <= mem_we_MEMEX;
            dbus_addr   <= word_addr_c;
            dbus_wdata  <= wdata_c;
            dbus_be     <= be_c;
            lat_addr_lo <= alu_result_MEMEX[1:0];
            lat_width   <= data_width_MEMEX;
            lat_sign    <= lsu_sign_extend_MEMEX;
            cnt         <= '0;
          end
        end
        BUSY: begin
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            if (!dbus_we) load_data_MEMEX <= load_ext;
          end else if (timeout_hit) begin
            dbus_req        <= 1'b0;
            lsu_fault       <= 1'b1;
            load_data_MEMEX <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_memex.sv
// Scoreboard bench for lsu_memex: stimulus queues expected bus/ITCM/fault
// events and completions; a negedge monitor pops and compares them.
module tb_lsu_memex;

  logic        clk = 1'b0;
  logic        rst;
  logic        invalid_MEMEX, mem_re_MEMEX, mem_we_MEMEX, itcm_we_MEMEX;
  logic [31:0] alu_result_MEMEX, rs2_data_MEMEX;
  logic [1:0]  data_width_MEMEX;
  logic        lsu_sign_extend_MEMEX;
  logic        dbus_req, dbus_we, dbus_ack;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        itcm_we;
  logic [31:0] itcm_addr, itcm_wdata;
  logic [3:0]  itcm_be;
  logic [31:0] load_data_MEMEX;
  logic        lsu_stall, lsu_misaligned, lsu_fault;

  always #5 clk = ~clk;

  lsu_memex #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .invalid_MEMEX(invalid_MEMEX), .mem_re_MEMEX(mem_re_MEMEX),
    .mem_we_MEMEX(mem_we_MEMEX), .itcm_we_MEMEX(itcm_we_MEMEX),
    .alu_result_MEMEX(alu_result_MEMEX), .data_width_MEMEX(data_width_MEMEX),
    .lsu_sign_extend_MEMEX(lsu_sign_extend_MEMEX), .rs2_data_MEMEX(rs2_data_MEMEX),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .itcm_we(itcm_we), .itcm_addr(itcm_addr),
    .itcm_wdata(itcm_wdata), .itcm_be(itcm_be), .load_data_MEMEX(load_data_MEMEX),
    .lsu_stall(lsu_stall), .lsu_misaligned(lsu_misaligned), .lsu_fault(lsu_fault)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} bus_t;
  typedef struct packed {logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} itcm_t;
  typedef struct packed {logic [7:0] stall_n; logic [7:0] req_n; logic fault; logic [31:0] load;} done_t;
  typedef struct packed {
    logic req; logic we; logic stall; logic mis; logic fault; logic iwe;
    logic [3:0] be; logic [31:0] addr; logic [31:0] load;
  } probe_t;

  bus_t   exp_bus[$];
  itcm_t  exp_itcm[$];
  done_t  exp_done[$];
  int     exp_mis[$];
  probe_t probe_exp;
  int     probe_seq = 0, probe_done = 0;
  int     fin_seq = 0, fin_done = 0;

  int          resp_delay = 0;
  logic [31:0] resp_data = '0;
  int          stray_seq = 0, stray_done = 0;

  int errors = 0, checks = 0;

  // Bus responder: ack after resp_delay BUSY cycles (0 = never); stray acks on request.
  initial begin
    int busy_n;
    busy_n     = 0;
    dbus_ack   = 1'b0;
    dbus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (dbus_req) begin
        busy_n++;
        dbus_ack   = (busy_n == resp_delay);
        dbus_rdata = dbus_ack ? resp_data : 32'h0;
      end else begin
        busy_n     = 0;
        dbus_ack   = (stray_seq != stray_done);
        dbus_rdata = dbus_ack ? 32'hDEAD_DEAD : 32'h0;
        stray_done = stray_seq;
      end
    end
  end

  task automatic chk(input bit ok, input string name, input logic [95:0] got, input logic [95:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: the only process that counts comparisons.
  initial begin
    logic   prev_stall, prev_req, fell;
    int     stall_n, req_n;
    probe_t pg;
    bus_t   bg, be_;
    itcm_t  ig, ie;
    done_t  dg, de;
    prev_stall = 1'b0; prev_req = 1'b0; stall_n = 0; req_n = 0;
    forever begin
      @(negedge clk);
      if (probe_seq != probe_done) begin
        pg = '{dbus_req, dbus_we, lsu_stall, lsu_misaligned, lsu_fault, itcm_we,
               dbus_be, dbus_addr, load_data_MEMEX};
        chk(pg == probe_exp, "probe", 96'(pg), 96'(probe_exp));
        probe_done = probe_seq;
      end
      if (fin_seq != fin_done) begin
        chk(exp_bus.size() == 0,  "leftover_bus",  96'(exp_bus.size()),  96'd0);
        chk(exp_itcm.size() == 0, "leftover_itcm", 96'(exp_itcm.size()), 96'd0);
        chk(exp_done.size() == 0, "leftover_done", 96'(exp_done.size()), 96'd0);
        chk(exp_mis.size() == 0,  "leftover_mis",  96'(exp_mis.size()),  96'd0);
        fin_done = fin_seq;
      end
      if (rst) begin
        prev_stall = 1'b0; prev_req = 1'b0; stall_n = 0; req_n = 0;
      end else begin
        if (dbus_req && !prev_req) begin
          bg = '{dbus_we, dbus_addr, dbus_be, dbus_wdata};
          if (exp_bus.size() == 0) chk(1'b0, "unexpected_bus", 96'(bg), 96'd0);
          else begin be_ = exp_bus.pop_front(); chk(bg == be_, "bus_req", 96'(bg), 96'(be_)); end
        end
        if (itcm_we) begin
          ig = '{itcm_addr, itcm_be, itcm_wdata};
          if (exp_itcm.size() == 0) chk(1'b0, "unexpected_itcm", 96'(ig), 96'd0);
          else begin ie = exp_itcm.pop_front(); chk(ig == ie, "itcm_write", 96'(ig), 96'(ie)); end
        end
        if (lsu_misaligned) begin
          if (exp_mis.size() == 0) chk(1'b0, "unexpected_misaligned", 96'd1, 96'd0);
          else begin
            void'(exp_mis.pop_front());
            chk({lsu_stall, itcm_we, dbus_req} == 3'b000, "misaligned_quiet",
                96'({lsu_stall, itcm_we, dbus_req}), 96'd0);
          end
        end
        if (lsu_stall) stall_n++;
        if (dbus_req)  req_n++;
        fell = prev_stall && !lsu_stall;
        if (fell) begin
          dg = '{8'(stall_n), 8'(req_n), lsu_fault, load_data_MEMEX};
          if (exp_done.size() == 0) chk(1'b0, "unexpected_done", 96'(dg), 96'd0);
          else begin de = exp_done.pop_front(); chk(dg == de, "done", 96'(dg), 96'(de)); end
          stall_n = 0; req_n = 0;
        end else if (lsu_fault) begin
          chk(1'b0, "stray_fault", 96'd1, 96'd0);
        end
        prev_stall = lsu_stall;
        prev_req   = dbus_req;
      end
    end
  end

  task automatic drive(input logic inv, input logic re, input logic we, input logic iwe,
                       input logic [31:0] addr, input logic [1:0] w, input logic sx,
                       input logic [31:0] rs2);
    invalid_MEMEX = inv; mem_re_MEMEX = re; mem_we_MEMEX = we; itcm_we_MEMEX = iwe;
    alu_result_MEMEX = addr; data_width_MEMEX = w;
    lsu_sign_extend_MEMEX = sx; rs2_data_MEMEX = rs2;
  endtask

  task automatic access(input logic inv, input logic re, input logic we, input logic iwe,
                        input logic [31:0] addr, input logic [1:0] w, input logic sx,
                        input logic [31:0] rs2, input int dly, input logic [31:0] rd);
    @(posedge clk); #2;
    drive(inv, re, we, iwe, addr, w, sx, rs2);
    resp_delay = dly; resp_data = rd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!lsu_stall) break;
    end
  endtask

  task automatic probe(input probe_t p);
    probe_exp = p;
    probe_seq++;
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    probe('0);
    @(posedge clk); #2 rst = 1'b0;
    probe('0);

    // Signed byte load, lane 3, two BUSY cycles.
    exp_bus.push_back('{1'b0, 32'h100, 4'b1000, 32'h0});
    exp_done.push_back('{8'd3, 8'd2, 1'b0, 32'hFFFF_FF80});
    access(0, 1, 0, 0, 32'h103, 2'b00, 1, 32'h0, 2, 32'h80FF_1234);
    // Half store, upper half, immediate ack; load data unchanged.
    exp_bus.push_back('{1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF});
    exp_done.push_back('{8'd2, 8'd1, 1'b0, 32'hFFFF_FF80});
    access(0, 0, 1, 0, 32'h202, 2'b01, 0, 32'hDEAD_BEEF, 1, 32'h0);
    // Misaligned word.
    exp_mis.push_back(1);
    access(0, 1, 0, 0, 32'h006, 2'b10, 0, 32'h0, 1, 32'h0);
    // Timeout: no ack.
    exp_bus.push_back('{1'b0, 32'h300, 4'b1111, 32'h1111_1111});
    exp_done.push_back('{8'd5, 8'd4, 1'b1, 32'h0});
    access(0, 1, 0, 0, 32'h300, 2'b10, 0, 32'h1111_1111, 0, 32'h0);
    // ITCM word store, then the same slot marked invalid.
    exp_itcm.push_back('{32'h40, 4'b1111, 32'h1234_5678});
    access(0, 0, 0, 1, 32'h40, 2'b10, 0, 32'h1234_5678, 1, 32'h0);
    access(1, 0, 0, 1, 32'h40, 2'b10, 0, 32'h1234_5678, 1, 32'h0);
    // Half loads, zero- and sign-extended.
    exp_bus.push_back('{1'b0, 32'h0, 4'b1100, 32'h0});
    exp_done.push_back('{8'd4, 8'd3, 1'b0, 32'h0000_8765});
    access(0, 1, 0, 0, 32'h002, 2'b01, 0, 32'h0, 3, 32'h8765_4321);
    exp_bus.push_back('{1'b0, 32'h0, 4'b1100, 32'h0});
    exp_done.push_back('{8'd2, 8'd1, 1'b0, 32'hFFFF_8765});
    access(0, 1, 0, 0, 32'h002, 2'b01, 1, 32'h0, 1, 32'h8765_4321);
    // Zero-extended byte, lane 1.
    exp_bus.push_back('{1'b0, 32'h0, 4'b0010, 32'h0});
    exp_done.push_back('{8'd2, 8'd1, 1'b0, 32'h0000_00AB});
    access(0, 1, 0, 0, 32'h001, 2'b00, 0, 32'h0, 1, 32'h0000_AB00);
    // Reserved width and odd half address.
    exp_mis.push_back(1);
    access(0, 1, 0, 0, 32'h000, 2'b11, 0, 32'h0, 1, 32'h0);
    exp_mis.push_back(1);
    access(0, 0, 1, 0, 32'h001, 2'b01, 0, 32'h0, 1, 32'h0);
    // Byte store lane 1.
    exp_bus.push_back('{1'b1, 32'h0, 4'b0010, 32'hA5A5_A5A5});
    exp_done.push_back('{8'd2, 8'd1, 1'b0, 32'h0000_00AB});
    access(0, 0, 1, 0, 32'h001, 2'b00, 0, 32'h0000_00A5, 1, 32'h0);
    // ITCM wins over data-bus store.
    exp_itcm.push_back('{32'h44, 4'b1100, 32'hCAFE_CAFE});
    access(0, 0, 1, 1, 32'h046, 2'b01, 0, 32'h0000_CAFE, 1, 32'h0);
    // Store wins over load.
    exp_bus.push_back('{1'b1, 32'h8, 4'b1111, 32'h55AA_55AA});
    exp_done.push_back('{8'd3, 8'd2, 1'b0, 32'h0000_00AB});
    access(0, 1, 1, 0, 32'h008, 2'b10, 0, 32'h55AA_55AA, 2, 32'h0);
    // Ack on the timeout cycle wins.
    exp_bus.push_back('{1'b0, 32'h10, 4'b1111, 32'h0});
    exp_done.push_back('{8'd5, 8'd4, 1'b0, 32'h0BAD_CAFE});
    access(0, 1, 0, 0, 32'h010, 2'b10, 0, 32'h0, 4, 32'h0BAD_CAFE);
    // Invalid slots: no side effects even when misaligned.
    access(1, 1, 0, 0, 32'h010, 2'b10, 0, 32'h0, 1, 32'h0);
    access(1, 1, 0, 0, 32'h003, 2'b10, 0, 32'h0, 1, 32'h0);

    // Reset in the second BUSY cycle, stray ack afterwards.
    exp_bus.push_back('{1'b0, 32'h20, 4'b1111, 32'h0});
    @(posedge clk); #2;
    drive(0, 1, 0, 0, 32'h020, 2'b10, 0, 32'h0);
    resp_delay = 0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    stray_seq++;
    drive(1, 0, 0, 0, 32'h0, 2'b00, 0, 32'h0);
    probe('0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 probe('0);
    exp_bus.push_back('{1'b0, 32'h10, 4'b1111, 32'h0});
    exp_done.push_back('{8'd2, 8'd1, 1'b0, 32'hCAFE_F00D});
    access(0, 1, 0, 0, 32'h010, 2'b10, 0, 32'h0, 1, 32'hCAFE_F00D);

    @(posedge clk); #2;
    drive(1, 0, 0, 0, 32'h0, 2'b00, 0, 32'h0);
    repeat (3) @(posedge clk);
    fin_seq++;
    for (int i = 0; i < 10 && fin_done != fin_seq; i++) @(posedge clk);
    if (fin_done != fin_seq) begin
      $display("FAIL monitor_final: monitor did not complete final checks");
      $fatal(1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_memex.md
Name: lsu_memex

Overview:
- Load/store unit on the consuming side of the MEMPREP→MEMEX pipeline register.
- Takes the registered MEMEX access fields (address, width, sign-extend, store data, ITCM write, invalid flag) and performs the access:
  - Data-bus accesses run over a req/ack handshake.
  - ITCM stores are single-cycle writes.
- Returns aligned, extended load data to writeback.
- Asserts lsu_stall so the MEMEX register and upstream stages hold during a bus transaction.

Parameters:
TIMEOUT_CYCLES, 16, max BUSY cycles waiting for dbus_ack before abort (1..255)

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
invalid_MEMEX  in  1  bubble/flushed slot; suppresses all side effects
mem_re_MEMEX  in  1  load request
mem_we_MEMEX  in  1  store request (data bus)
itcm_we_MEMEX  in  1  store request (ITCM)
alu_result_MEMEX  in  32  byte address
data_width_MEMEX  in  2  00 byte, 01 half, 10 word, 11 reserved
lsu_sign_extend_MEMEX  in  1  1 = sign-extend load, 0 = zero-extend
rs2_data_MEMEX  in  32  store data
dbus_req  out  1  bus request, held until ack
dbus_we  out  1  1 = write
dbus_addr  out  32  word address ({addr[31:2],2'b00})
dbus_wdata  out  32  lane-replicated store data
dbus_be  out  4  byte enables
dbus_ack  in  1  responder completion, single-cycle pulse
dbus_rdata  in  32  read data, valid with dbus_ack
itcm_we  out  1  ITCM write strobe
itcm_addr  out  32  word address
itcm_wdata  out  32  lane-replicated store data
itcm_be  out  4  byte enables
load_data_MEMEX  out  32  aligned/extended load result
lsu_stall  out  1  hold pipeline
lsu_misaligned  out  1  alignment/width fault pulse
lsu_fault  out  1  bus timeout pulse

Behaviour:
- Reset values: IDLE, dbus_req=0, dbus_we=0, dbus_addr/wdata/be=0, itcm_*=0, load_data_MEMEX=0, stall/misaligned/fault=0, timeout counter=0. Reset mid-transaction drops dbus_req immediately; any later ack is ignored.
- Access condition: valid = !invalid_MEMEX & (mem_re | mem_we | itcm_we).
- Misaligned when any of:
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - width 11.
- Byte enables:
  - byte: 4'b0001<<addr[1:0];
  - half: 4'b0011<<{addr[1],1'b0};
  - word: 4'b1111.
- Write data:
  - byte: {4{rs2[7:0]}};
  - half: {2{rs2[15:0]}};
  - word: rs2.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Valid misaligned access:
    - lsu_misaligned combinational high this cycle;
    - no bus/ITCM activity;
    - no stall;
    - stay IDLE.
  - Valid aligned itcm_we:
    - itcm_we/addr/wdata/be driven combinationally this cycle;
    - no stall;
    - stay IDLE.
    - itcm_we has priority over mem_we/mem_re if several are set.
  - Valid aligned mem_re or mem_we:
    - lsu_stall combinational high;
    - latch addr/width/sign/be/wdata/we;
    - next state BUSY with dbus_req=1 registered.
    - mem_we has priority over mem_re.
- BUSY:
  - dbus_req=1, all dbus_* stable, lsu_stall=1, counter increments.
  - dbus_ack=1:
    - on a read, capture dbus_rdata, select lane by latched addr[1:0], extend per width/sign into load_data_MEMEX;
    - drop dbus_req;
    - go to DONE.
    - Earliest ack is the first BUSY cycle.
  - Counter reaches TIMEOUT_CYCLES with no ack:
    - drop dbus_req;
    - lsu_fault pulse 1 cycle;
    - load_data_MEMEX=0;
    - go to DONE.
  - Ack arriving in the same cycle as timeout: ack wins, no fault.
- DONE:
  - lsu_stall=0; load_data_MEMEX valid; pipeline advances at this clock edge.
  - Go to IDLE; the new MEMEX slot is evaluated from the next cycle.
- Latency: bus access occupies minimum 3 cycles (issue, BUSY, DONE), so stall is high for 2 cycles minimum.
- Store leaves load_data_MEMEX unchanged.
- dbus_ack seen in IDLE or DONE is ignored.
- invalid_MEMEX=1 forces no stall, no strobes, and no faults, regardless of the other fields.

Test Plan:
1. Load byte, sign=1, addr 0x103, ack after 2 BUSY cycles with rdata 0x80FF_1234 → dbus_addr 0x100, be 0000 (read, be ignored/driven 1000), load_data 0xFFFF_FF80, lsu_stall high for 3 cycles.
2. Store half, addr 0x202, rs2 0xDEAD_BEEF, immediate ack → dbus_we=1, be 1100, wdata 0xBEEF_BEEF, stall 2 cycles.
3. Load word at 0x006 → lsu_misaligned 1 cycle, dbus_req never asserts, no stall.
4. Load with no ack, TIMEOUT_CYCLES=4 → dbus_req high 4 cycles then low, lsu_fault pulse, load_data 0, stall released in DONE.
5. itcm_we word, addr 0x40, rs2 0x1234_5678 → itcm_we pulse the same cycle, be 1111, no stall; then the same access with invalid_MEMEX=1 → no strobe.
6. Assert rst in the second BUSY cycle, then ack one cycle later → dbus_req low immediately, FSM IDLE, the ack is ignored and load_data stays 0.
